// File: rtl/cv32e40x_alignment_buffer.sv
// Instruction alignment buffer: issues word fetches, queues response words and presents
// halfword-aligned instructions. Define CV32E40X_ALIGN_BUF_BYPASS_EN for zero-latency response forwarding.
module cv32e40x_alignment_buffer #(
  parameter int DEPTH           = 3,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        trans_valid_o,
  input  logic        trans_ready_i,
  output logic [31:0] trans_addr_o,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_rdata_i,
  input  logic        resp_err_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_err_o,
  output logic        one_txn_pend_n_o,
  output logic        busy_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {ALIGNED = 1'b0, MISALIGNED = 1'b1} state_t;

  state_t           state;
  logic [31:0]      mem_data [DEPTH];
  logic [DEPTH-1:0] mem_err;
  logic [PW-1:0]    rptr, wptr, rptr1;
  logic [CW-1:0]    count, outstanding, discard, outstanding_next;
  logic [31:0]      fetch_addr, instr_addr, addr_next;
  logic [31:0]      w0;
  logic [15:0]      w1_lo, h;
  logic             e0, e1;
  logic             resp_take, trans_fire, push, pop, fire, crossed;
  logic             valid_raw, compressed, bypass0;
  logic [31:0]      rdata;
  logic             err;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rptr1 = nxt(rptr);
  assign w0    = mem_data[rptr];
  assign e0    = mem_err[rptr];
  assign w1_lo = mem_data[rptr1][15:0];
  assign e1    = mem_err[rptr1];

  // Responses only count against transactions issued since the last reset.
  assign resp_take  = resp_valid_i && (outstanding != '0);
  assign trans_valid_o = fetch_en_i && !branch_i
                      && (outstanding < CW'(MAX_OUTSTANDING))
                      && (({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
  assign trans_addr_o = fetch_addr;
  assign trans_fire   = trans_valid_o && trans_ready_i;

  always_comb begin
    valid_raw  = 1'b0;
    compressed = 1'b0;
    rdata      = '0;
    err        = 1'b0;
    bypass0    = 1'b0;
    h          = w0[31:16];
    if (count != '0) begin
      if (state == ALIGNED) begin
        compressed = (w0[1:0] != 2'b11);
        valid_raw  = 1'b1;
        rdata      = w0;
        err        = e0;
      end else begin
        compressed = (h[1:0] != 2'b11);
        if (e0) begin
          valid_raw = 1'b1;
          err       = 1'b1;
          rdata     = {16'h0, h};
        end else if (compressed) begin
          valid_raw = 1'b1;
          rdata     = {16'h0, h};
        end else if (count > CW'(1)) begin
          valid_raw = 1'b1;
          rdata     = {w1_lo, h};
          err       = e1;
        end
`ifdef CV32E40X_ALIGN_BUF_BYPASS_EN
        else if (resp_take && (discard == '0)) begin
          valid_raw = 1'b1;
          rdata     = {resp_rdata_i[15:0], h};
          err       = resp_err_i;
        end
`endif
      end
    end
`ifdef CV32E40X_ALIGN_BUF_BYPASS_EN
    else if ((state == ALIGNED) && (discard == '0) && resp_take) begin
      compressed = (resp_rdata_i[1:0] != 2'b11);
      valid_raw  = 1'b1;
      rdata      = resp_rdata_i;
      err        = resp_err_i;
      bypass0    = 1'b1;
    end
`endif
  end

  assign instr_valid_o = valid_raw && !branch_i;
  assign instr_rdata_o = rdata;
  assign instr_err_o   = err;
  assign instr_addr_o  = instr_addr;

  // The head word retires once the instruction ends on or runs past its upper boundary.
  assign fire      = instr_valid_o && instr_ready_i;
  assign addr_next = instr_addr + (compressed ? 32'd2 : 32'd4);
  assign crossed   = !compressed || instr_addr[1];
  assign pop       = fire && crossed && !bypass0;
  assign push      = resp_take && (discard == '0) && !branch_i && !(bypass0 && fire && crossed);

  assign outstanding_next = outstanding + CW'(trans_fire) - CW'(resp_take);
  assign one_txn_pend_n_o = (outstanding_next <= CW'(1));
  assign busy_o           = (outstanding != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ALIGNED;
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      fetch_addr  <= '0;
      instr_addr  <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (branch_i) begin
        rptr       <= '0;
        wptr       <= '0;
        count      <= '0;
        discard    <= outstanding - CW'(resp_take);
        fetch_addr <= {branch_addr_i[31:2], 2'b00};
        instr_addr <= branch_addr_i;
        state      <= branch_addr_i[1] ? MISALIGNED : ALIGNED;
      end else begin
        if (trans_fire) fetch_addr <= fetch_addr + 32'd4;
        if (resp_take && (discard != '0)) discard <= discard - CW'(1);
        if (push) wptr <= nxt(wptr);
        if (pop) rptr <= nxt(rptr);
        count <= count + CW'(push) - CW'(pop);
        if (fire) begin
          instr_addr <= addr_next;
          state      <= addr_next[1] ? MISALIGNED : ALIGNED;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wptr] <= resp_rdata_i;
      mem_err[wptr]  <= resp_err_i;
    end
  end

endmodule

// File: tb/tb_cv32e40x_alignment_buffer.sv
// Scoreboard bench for cv32e40x_alignment_buffer in its default build (DEPTH=3, MAX_OUTSTANDING=2).
`timescale 1ns/1ps
module tb_cv32e40x_alignment_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en_i, branch_i, trans_ready_i, instr_ready_i;
  logic [31:0] branch_addr_i;
  logic        trans_valid_o, instr_valid_o, instr_err_o, one_txn_pend_n_o, busy_o;
  logic [31:0] trans_addr_o, instr_rdata_o, instr_addr_o;
  logic        resp_valid_i, resp_err_i;
  logic [31:0] resp_rdata_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] mask;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] req_log[$];
  logic [31:0] mem_d [logic [31:0]];
  logic        mem_e [logic [31:0]];
  int          checks = 0, errors = 0, consumed = 0;
  logic        hold_all = 1'b0, hold_en = 1'b0;
  logic [31:0] hold_addr = '0;

  always #5 clk = ~clk;

  cv32e40x_alignment_buffer #(.DEPTH(3), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst), .fetch_en_i(fetch_en_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i),
    .trans_addr_o(trans_addr_o), .resp_valid_i(resp_valid_i), .resp_rdata_i(resp_rdata_i),
    .resp_err_i(resp_err_i), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_rdata_o(instr_rdata_o), .instr_addr_o(instr_addr_o), .instr_err_o(instr_err_o),
    .one_txn_pend_n_o(one_txn_pend_n_o), .busy_o(busy_o)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_d.exists(a)) return mem_d[a];
    return 32'h0000_0013;
  endfunction

  function automatic logic rde(input logic [31:0] a);
    if (mem_e.exists(a)) return mem_e[a];
    return 1'b0;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_branch(input logic [31:0] a);
    branch_i      = 1'b1;
    branch_addr_i = a;
    cyc(1);
    branch_i      = 1'b0;
  endtask

  task automatic expect_instr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m, input logic e);
    exp_t x;
    x.addr = a; x.rdata = d; x.mask = m; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic wait_consumed(input int target, input string name);
    int n;
    n = 0;
    while (consumed < target && n < 60) begin
      cyc(1);
      n++;
    end
    instr_ready_i = 1'b0;
    checks++;
    if (consumed < target) begin
      errors++;
      $display("FAIL %s_timeout: consumed %0d, required %0d", name, consumed, target);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    fetch_en_i = 1'b0;
    while (busy_o && n < 40) begin
      cyc(1);
      n++;
    end
    cyc(2);
    checks++;
    if (busy_o) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy %b, required 0", name, busy_o);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk32({tag, "_trans_valid"}, 32'(trans_valid_o), 32'd0);
    chk32({tag, "_instr_valid"}, 32'(instr_valid_o), 32'd0);
    chk32({tag, "_instr_err"},   32'(instr_err_o), 32'd0);
    chk32({tag, "_busy"},        32'(busy_o), 32'd0);
    chk32({tag, "_one_txn"},     32'(one_txn_pend_n_o), 32'd1);
    chk32({tag, "_rdata"},       instr_rdata_o, 32'h0);
    chk32({tag, "_instr_addr"},  instr_addr_o, 32'h0);
    chk32({tag, "_trans_addr"},  trans_addr_o, 32'h0);
  endtask

  // Request sampler: a request seen before the edge is accepted at that edge.
  initial forever begin
    @(negedge clk);
    if (!rst && trans_valid_o && trans_ready_i) begin
      pend_q.push_back(trans_addr_o);
      req_log.push_back(trans_addr_o);
    end
  end

  // Memory responder: in-order, one cycle after acceptance unless held.
  initial begin : responder
    logic [31:0] a;
    forever begin
      @(posedge clk);
      #2;
      if (pend_q.size() != 0 && !hold_all && !(hold_en && pend_q[0] == hold_addr)) begin
        a            = pend_q.pop_front();
        resp_valid_i = 1'b1;
        resp_rdata_i = rd(a);
        resp_err_i   = rde(a);
      end else begin
        resp_valid_i = 1'b0;
        resp_rdata_i = '0;
        resp_err_i   = 1'b0;
      end
    end
  end

  // Monitor: every consumed instruction is popped from the scoreboard and compared.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid_o && instr_ready_i) begin
        consumed++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL instr_unexpected: got addr %h rdata %h err %b, required no instruction",
                   instr_addr_o, instr_rdata_o, instr_err_o);
        end else begin
          e = exp_q.pop_front();
          if (instr_addr_o !== e.addr || (instr_rdata_o & e.mask) !== (e.rdata & e.mask) ||
              instr_err_o !== e.err) begin
            errors++;
            $display("FAIL instr_%h: got addr %h rdata %h err %b, required addr %h rdata %h mask %h err %b",
                     e.addr, instr_addr_o, instr_rdata_o, instr_err_o, e.addr, e.rdata, e.mask, e.err);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, tgt;
    rst = 1'b1; fetch_en_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
    trans_ready_i = 1'b1; instr_ready_i = 1'b0;
    mem_d[32'h100] = 32'h0000_0013; mem_d[32'h104] = 32'h00A0_0093;
    mem_d[32'h200] = 32'h4505_0001; mem_d[32'h204] = 32'h00A0_0513;
    mem_d[32'h300] = 32'h0093_0000; mem_d[32'h304] = 32'h1111_00A0;
    mem_d[32'h380] = 32'h00C0_0193; mem_d[32'h384] = 32'h00C0_0193;
    mem_d[32'h400] = 32'h00B0_0113;
    mem_d[32'h500] = 32'h0093_0000; mem_e[32'h500] = 1'b1;
    cyc(3);
    rst = 1'b0;
    #3;
    chk_reset_outputs("reset");

    // Sequential aligned fetch.
    cyc(1);
    tgt  = consumed + 2;
    base = req_log.size();
    expect_instr(32'h100, 32'h0000_0013, 32'hFFFF_FFFF, 1'b0);
    expect_instr(32'h104, 32'h00A0_0093, 32'hFFFF_FFFF, 1'b0);
    fetch_en_i = 1'b1;
    do_branch(32'h100);
    instr_ready_i = 1'b1;
    wait_consumed(tgt, "seq");
    cyc(8);
    #3;
    chk32("seq_busy_after_fill", 32'(busy_o), 32'd0);
    chk32("seq_full_no_request", 32'(trans_valid_o), 32'd0);
    if (req_log.size() >= base + 2) begin
      chk32("seq_req0_addr", req_log[base], 32'h100);
      chk32("seq_req1_addr", req_log[base+1], 32'h104);
    end else begin
      checks++; errors++;
      $display("FAIL seq_requests: got %0d requests, required at least 2", req_log.size() - base);
    end

    // Misaligned compressed then aligned uncompressed.
    cyc(1);
    tgt = consumed + 2;
    expect_instr(32'h202, 32'h0000_4505, 32'h0000_FFFF, 1'b0);
    expect_instr(32'h204, 32'h00A0_0513, 32'hFFFF_FFFF, 1'b0);
    do_branch(32'h202);
    instr_ready_i = 1'b1;
    wait_consumed(tgt, "misal");
    cyc(1);
    #3;
    chk32("misal_next_pc", instr_addr_o, 32'h208);

    // Straddling uncompressed instruction waits for its second word.
    cyc(1);
    hold_en = 1'b1; hold_addr = 32'h304;
    tgt = consumed + 2;
    expect_instr(32'h302, 32'h00A0_0093, 32'hFFFF_FFFF, 1'b0);
    expect_instr(32'h306, 32'h0000_1111, 32'h0000_FFFF, 1'b0);
    do_branch(32'h302);
    cyc(8);
    #3;
    chk32("straddle_wait_valid", 32'(instr_valid_o), 32'd0);
    cyc(1);
    hold_en = 1'b0;
    instr_ready_i = 1'b1;
    wait_consumed(tgt, "straddle");

    // Two stale transactions outstanding across a branch.
    wait_idle("stale");
    hold_all = 1'b1;
    fetch_en_i = 1'b1;
    do_branch(32'h380);
    cyc(5);
    #3;
    chk32("stale_busy", 32'(busy_o), 32'd1);
    chk32("stale_max_outstanding", 32'(trans_valid_o), 32'd0);
    chk32("stale_one_txn", 32'(one_txn_pend_n_o), 32'd0);
    cyc(1);
    tgt = consumed + 1;
    expect_instr(32'h400, 32'h00B0_0113, 32'hFFFF_FFFF, 1'b0);
    do_branch(32'h400);
    hold_all = 1'b0;
    instr_ready_i = 1'b1;
    wait_consumed(tgt, "stale");

    // Error on the first word of a straddling instruction is presented at once.
    cyc(1);
    hold_en = 1'b1; hold_addr = 32'h504;
    tgt = consumed + 1;
    expect_instr(32'h502, 32'h0, 32'h0, 1'b1);
    do_branch(32'h502);
    instr_ready_i = 1'b1;
    wait_consumed(tgt, "err");
    cyc(3);
    #3;
    chk32("err_then_wait_valid", 32'(instr_valid_o), 32'd0);
    chk32("err_next_pc", instr_addr_o, 32'h506);
    cyc(1);
    hold_en = 1'b0;

    // Fill with the consumer stalled.
    wait_idle("fill");
    instr_ready_i = 1'b0;
    base = req_log.size();
    fetch_en_i = 1'b1;
    do_branch(32'h600);
    cyc(10);
    #3;
    chk32("fill_transfer_count", 32'(req_log.size() - base), 32'd3);
    chk32("fill_no_request", 32'(trans_valid_o), 32'd0);

    // Reset while traffic is in flight.
    cyc(1);
    do_branch(32'h700);
    cyc(2);
    rst = 1'b1;
    fetch_en_i = 1'b0;
    cyc(1);
    rst = 1'b0;
    #3;
    chk_reset_outputs("midrst");
    cyc(4);
    #3;
    chk32("midrst_late_busy", 32'(busy_o), 32'd0);
    chk32("midrst_late_valid", 32'(instr_valid_o), 32'd0);
    chk32("midrst_late_one_txn", 32'(one_txn_pend_n_o), 32'd1);
    chk32("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
